// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the serial packed-BCD adder/subtractor.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned BCD_MAX     = 9;
    localparam int unsigned BCD_CORR    = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } bcd_state_e;

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Operand/result handshake bundle for bcd_serial_adder; master is the producer/consumer side.
interface bcd_serial_adder_if
    import bcd_pkg::*;
#(
    parameter int unsigned NDIGITS = 4
);

    localparam int unsigned W = BCD_DIGIT_W * NDIGITS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         err;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, err
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, err
    );

endinterface

// File: rtl/bcd_digit_add.sv
// One decimal digit of add or nine's-complement subtract, with +6 correction above 9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    input  logic       i_sub,
    output logic [3:0] o_s,
    output logic       o_cout,
    output logic       o_bad
);

    logic [3:0] w_bx;
    logic [4:0] w_sum;
    logic [4:0] w_corr;

    // 4-bit wrap on 9-b keeps invalid digits on the same arithmetic path
    assign w_bx   = i_sub ? (4'(BCD_MAX) - i_b) : i_b;
    assign w_sum  = 5'(i_a) + 5'(w_bx) + 5'(i_cin);
    assign w_corr = w_sum + 5'(BCD_CORR);

    always_comb begin
        o_s    = w_sum[3:0];
        o_cout = 1'b0;
        if (w_sum > 5'(BCD_MAX)) begin
            o_s    = w_corr[3:0];
            o_cout = 1'b1;
        end
        o_bad = (i_a > 4'(BCD_MAX)) || (i_b > 4'(BCD_MAX));
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder/subtractor processing one digit per clock, LSD first.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int unsigned NDIGITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    bcd_serial_adder_if.slave  bus
);

    localparam int unsigned W        = BCD_DIGIT_W * NDIGITS;
    localparam int unsigned IDX_W    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);

    bcd_state_e       r_state;
    bcd_state_e       w_state_nxt;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_res;
    logic             r_sub;
    logic             r_carry;
    logic             r_err;
    logic [IDX_W-1:0] r_idx;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [3:0]       w_s;
    logic             w_cout;
    logic             w_bad;
    logic [W+3:0]     w_res_shift;

    bcd_digit_add u_digit (
        .i_a    (r_a[BCD_DIGIT_W-1:0]),
        .i_b    (r_b[BCD_DIGIT_W-1:0]),
        .i_cin  (r_carry),
        .i_sub  (r_sub),
        .o_s    (w_s),
        .o_cout (w_cout),
        .o_bad  (w_bad)
    );

    assign w_last = (r_idx == IDX_LAST);
    // New digit enters at the top so digit 0 lands in [3:0] after NDIGITS shifts
    assign w_res_shift = {w_s, r_res} >> BCD_DIGIT_W;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_run       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                w_run = 1'b1;
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_sub   <= bus.sub;
            r_carry <= bus.sub;
            r_err   <= 1'b0;
            r_idx   <= '0;
        end else if (w_run) begin
            r_a     <= r_a >> BCD_DIGIT_W;
            r_b     <= r_b >> BCD_DIGIT_W;
            r_res   <= w_res_shift[W-1:0];
            r_carry <= w_cout;
            r_err   <= r_err | w_bad;
            if (!w_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.result    = r_res;
    assign bus.cout      = r_carry;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed and random checks of bcd_serial_adder against a decimal integer model.
module tb_bcd_serial_adder;

    typedef struct packed {
        logic [15:0] res;
        logic        cout;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    int   n_fail;
    exp_t sb[$];

    bcd_serial_adder_if #(.NDIGITS(4)) bus4 ();
    bcd_serial_adder_if #(.NDIGITS(1)) bus1 ();

    bcd_serial_adder #(.NDIGITS(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    bcd_serial_adder #(.NDIGITS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic exp_t model4(input logic [15:0] a, input logic [15:0] b, input logic s);
        exp_t e;
        int ia = bcd2int(a);
        int ib = bcd2int(b);
        int r;
        e.err = 1'b0;
        if (!s) begin
            r      = ia + ib;
            e.cout = (r >= 10000);
            r      = r % 10000;
        end else if (ia >= ib) begin
            r      = ia - ib;
            e.cout = 1'b1;
        end else begin
            r      = 10000 - (ib - ia);
            e.cout = 1'b0;
        end
        e.res = int2bcd(r);
        return e;
    endfunction

    // Latency counts edges from the accepting edge (as 1) to the edge raising out_valid
    task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input exp_t e, input int exp_lat);
        int   lat;
        int   w;
        exp_t got;
        bus4.a        = a;
        bus4.b        = b;
        bus4.sub      = s;
        bus4.in_valid = 1'b1;
        w = 0;
        while (!bus4.in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus4.in_ready) check("accept_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        sb.push_back(e);
        lat = 1;
        while (!bus4.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus4.out_valid) begin
            check("done_timeout", 32'(0), 32'(1));
        end else if (sb.size() == 0) begin
            check("sb_empty", 32'(0), 32'(1));
        end else begin
            got = sb.pop_front();
            check("result", 32'(bus4.result), 32'(got.res));
            check("cout", 32'(bus4.cout), 32'(got.cout));
            check("err", 32'(bus4.err), 32'(got.err));
            if (exp_lat > 0) check("latency", 32'(lat), 32'(exp_lat));
        end
        if (bus4.out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        exp_t        e;
        logic [15:0] held;
        logic        seen;
        int          lat;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;

        n_pass = 0;
        n_total = 0;
        n_fail = 0;
        rst = 1'b1;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.sub = 1'b0; bus4.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0; bus1.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", 32'(bus4.in_ready), 32'(1));
        check("rst_out_valid", 32'(bus4.out_valid), 32'(0));
        check("rst_result", 32'(bus4.result), 32'(0));
        check("rst_cout", 32'(bus4.cout), 32'(0));
        check("rst_err", 32'(bus4.err), 32'(0));

        e = '{res: 16'h6912, cout: 1'b0, err: 1'b0};
        op4(16'h1234, 16'h5678, 1'b0, e, 5);
        e = '{res: 16'h0000, cout: 1'b1, err: 1'b0};
        op4(16'h9999, 16'h0001, 1'b0, e, 5);
        e = '{res: 16'h0099, cout: 1'b1, err: 1'b0};
        op4(16'h0100, 16'h0001, 1'b1, e, 5);
        e = '{res: 16'h9999, cout: 1'b0, err: 1'b0};
        op4(16'h0001, 16'h0002, 1'b1, e, 5);
        e = '{res: 16'h1304, cout: 1'b0, err: 1'b1};
        op4(16'h12A4, 16'h0000, 1'b0, e, 5);
        e = '{res: 16'h4321, cout: 1'b0, err: 1'b0};
        op4(16'h4321, 16'h0000, 1'b0, e, 5);

        // Backpressure: result held, a pending request is refused until the handshake
        bus4.out_ready = 1'b0;
        e = '{res: 16'h5555, cout: 1'b0, err: 1'b0};
        op4(16'h1234, 16'h4321, 1'b0, e, 5);
        held = bus4.result;
        bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.sub = 1'b0; bus4.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(bus4.out_valid), 32'(1));
            check("bp_result", 32'(bus4.result), 32'(16'h5555));
            check("bp_in_ready", 32'(bus4.in_ready), 32'(0));
        end
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", 32'(bus4.in_ready), 32'(1));
        check("bp_release_valid", 32'(bus4.out_valid), 32'(0));
        check("bp_result_idle", 32'(bus4.result), 32'(held));
        op4(16'h1111, 16'h2222, 1'b0, model4(16'h1111, 16'h2222, 1'b0), 5);

        // Reset while processing digit 2
        bus4.a = 16'h5678; bus4.b = 16'h1111; bus4.sub = 1'b0; bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(bus4.in_ready), 32'(1));
        check("mid_rst_out_valid", 32'(bus4.out_valid), 32'(0));
        check("mid_rst_result", 32'(bus4.result), 32'(0));
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus4.out_valid) seen = 1'b1;
        end
        check("no_stale_valid", 32'(seen), 32'(0));

        // Single-digit instance
        bus1.a = 4'h9; bus1.b = 4'h9; bus1.sub = 1'b0; bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        lat = 1;
        while (!bus1.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("n1_result", 32'(bus1.result), 32'(4'h8));
        check("n1_cout", 32'(bus1.cout), 32'(1));
        check("n1_latency", 32'(lat), 32'(2));
        @(posedge clk); #1;
        check("n1_idle", 32'(bus1.in_ready), 32'(1));

        // Random back-to-back operations
        for (int i = 0; i < 1000; i++) begin
            ra = int2bcd(int'($urandom_range(0, 9999)));
            rb = int2bcd(int'($urandom_range(0, 9999)));
            rs = 1'($urandom_range(0, 1));
            op4(ra, rb, rs, model4(ra, rb, rs), 0);
        end

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
